// File: rtl/crypto_fu_sched.sv
// Issue scheduler sharing one crypto scalar FU among NR_REQ requesters.
// Round-robin issue, one op in flight, PRNG seed tracking and post-seed warmup.
package crypto_instr_pkg;
  typedef enum logic [3:0] {
    OP_NONE        = 4'd0,
    OP_SHA256_SIG0 = 4'd1,
    OP_SHA256_SIG1 = 4'd2,
    OP_SHA256_SUM0 = 4'd3,
    OP_SHA256_SUM1 = 4'd4,
    OP_SM3_P0      = 4'd5,
    OP_SM3_P1      = 4'd6,
    OP_PRNG        = 4'd7,
    OP_XOR_R       = 4'd8
  } opcode_t;
endpackage

// state  | meaning
// IDLE   | arbitrate; winner driven onto the FU bus in its accept cycle
// BUSY   | waiting for fu_valid_i
// RESP   | response held for the owner until resp_ready_i[owner]
// WARMUP | PRNG settling after a seed op; no accepts
module crypto_fu_sched
  import crypto_instr_pkg::*;
#(
  parameter int unsigned NR_REQ        = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned WARMUP_CYCLES = 4,
  parameter opcode_t     IDLE_OP       = OP_NONE
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic    [NR_REQ-1:0]           req_valid_i,
  output logic    [NR_REQ-1:0]           req_ready_o,
  input  opcode_t [NR_REQ-1:0]           req_op_i,
  input  logic    [NR_REQ-1:0][XLEN-1:0] req_rs1_i,
  input  logic    [NR_REQ-1:0][XLEN-1:0] req_rs2_i,
  input  logic    [NR_REQ-1:0][31:0]     req_instr_i,
  input  logic    [NR_REQ-1:0][4:0]      req_rd_i,
  output opcode_t                        fu_op_o,
  output logic    [XLEN-1:0]             fu_rs1_o,
  output logic    [XLEN-1:0]             fu_rs2_o,
  output logic    [31:0]                 fu_instr_o,
  output logic    [4:0]                  fu_rd_o,
  input  logic                           fu_valid_i,
  input  logic    [XLEN-1:0]             fu_result_i,
  output logic    [NR_REQ-1:0]           resp_valid_o,
  input  logic    [NR_REQ-1:0]           resp_ready_i,
  output logic    [XLEN-1:0]             resp_result_o,
  output logic    [4:0]                  resp_rd_o,
  output logic                           resp_err_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESP   = 2'd2,
    S_WARMUP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  owner_q;
  logic              seeded_q;
  logic              seed_op_q;
  logic [7:0]        cnt_q;
  logic [XLEN-1:0]   resp_result_q;
  logic [4:0]        resp_rd_q;
  logic              resp_err_q;

  logic [IDX_W-1:0]  winner;
  logic              grant_found;
  logic              accept;
  logic              win_prng;
  logic              win_seed;
  logic              win_unseed;
  logic              xor_blocked;
  logic              issue;
  logic              resp_hs;

  // Rotating priority: search starts just after the last granted requester.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    winner      = '0;
    grant_found = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 1; i <= NR_REQ; i++) begin
      cand     = (32'(last_grant_q) + i) % NR_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        winner      = cand_idx;
      end
    end
  end

  assign accept      = (state_q == S_IDLE) && grant_found && !rst_i;
  assign win_prng    = (req_op_i[winner] == OP_PRNG);
  assign win_seed    = win_prng && (req_instr_i[winner][27:25] == 3'b101);
  assign win_unseed  = win_prng && (req_instr_i[winner][27:25] == 3'b111);
  assign xor_blocked = (req_op_i[winner] == OP_XOR_R) && !seeded_q;
  assign issue       = accept && !xor_blocked;
  assign resp_hs     = (state_q == S_RESP) && resp_ready_i[owner_q];

  assign req_ready_o  = accept ? (NR_REQ'(1) << winner) : '0;
  assign fu_op_o      = issue ? req_op_i[winner]    : IDLE_OP;
  assign fu_rs1_o     = issue ? req_rs1_i[winner]   : '0;
  assign fu_rs2_o     = issue ? req_rs2_i[winner]   : '0;
  assign fu_instr_o   = issue ? req_instr_i[winner] : '0;
  assign fu_rd_o      = issue ? req_rd_i[winner]    : '0;

  assign resp_valid_o  = (state_q == S_RESP) ? (NR_REQ'(1) << owner_q) : '0;
  assign resp_result_o = resp_result_q;
  assign resp_rd_o     = resp_rd_q;
  assign resp_err_o    = resp_err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = xor_blocked ? S_RESP : S_BUSY;
      S_BUSY:   if (fu_valid_i) state_d = S_RESP;
      S_RESP:   if (resp_hs) state_d = (seed_op_q && (WARMUP_CYCLES > 0)) ? S_WARMUP : S_IDLE;
      S_WARMUP: if (cnt_q <= 8'd1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      last_grant_q  <= IDX_W'(NR_REQ - 1);
      owner_q       <= '0;
      seeded_q      <= 1'b0;
      seed_op_q     <= 1'b0;
      cnt_q         <= '0;
      resp_result_q <= '0;
      resp_rd_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= winner;
        owner_q      <= winner;
        seed_op_q    <= win_seed;
        resp_rd_q    <= req_rd_i[winner];
        if (win_seed) begin
          seeded_q <= 1'b1;
        end else if (win_unseed) begin
          seeded_q <= 1'b0;
        end
        // Unseeded XOR_R never reaches the FU; it is answered with an error.
        if (xor_blocked) begin
          resp_result_q <= '0;
          resp_err_q    <= 1'b1;
        end
      end
      if ((state_q == S_BUSY) && fu_valid_i) begin
        resp_result_q <= fu_result_i;
        resp_err_q    <= 1'b0;
      end
      if (resp_hs && (state_d == S_WARMUP)) begin
        cnt_q <= 8'(WARMUP_CYCLES);
      end else if (state_q == S_WARMUP) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

endmodule

// File: doc/crypto_fu_sched.md
CRYPTO_FU_SCHED -- requirements
Module: crypto_fu_sched

Interface
REQ-001: Parameter NR_REQ, 2, number of requesters sharing the crypto scalar FU (legal 2..4).
REQ-002: Parameter XLEN, 64, operand/result width.
REQ-003: Parameter WARMUP_CYCLES, 4, PRNG settle cycles after a seed op (legal 0..255).
REQ-004: Parameter IDLE_OP, crypto_instr_pkg opcode_t value the FU treats as no-op (default branch); driven on fu_op_o when not issuing.
REQ-005: clk_i  in  1  single clock, all state on rising edge.
REQ-006: rst_i  in  1  reset, asynchronous, active-high.
REQ-007: req_valid_i / req_ready_o  in/out  NR_REQ  per-requester valid/ready; transfer when both high on a clock edge.
REQ-008: req_op_i  in  NR_REQ x opcode_t  requested operation.
REQ-009: req_rs1_i, req_rs2_i  in  NR_REQ x XLEN  source operands.
REQ-010: req_instr_i  in  NR_REQ x 32; req_rd_i  in  NR_REQ x 5  raw instruction and destination register.
REQ-011: fu_op_o  out  opcode_t; fu_rs1_o, fu_rs2_o  out  XLEN; fu_instr_o  out  32; fu_rd_o  out  5  FU issue bus.
REQ-012: fu_valid_i  in  1; fu_result_i  in  XLEN  FU registered result, nominal one cycle after issue.
REQ-013: resp_valid_o  out  NR_REQ (one-hot); resp_ready_i  in  NR_REQ  per-requester response handshake.
REQ-014: resp_result_o  out  XLEN; resp_rd_o  out  5; resp_err_o  out  1  shared response payload, meaningful only while a resp_valid_o bit is set.

Function
REQ-015: FSM states IDLE, BUSY, RESP, WARMUP; exactly one operation in flight at any time.
REQ-016: IDLE: round-robin arbitration over req_valid_i, starting at requester (last_grant+1) mod NR_REQ; req_ready_o high combinationally for the winner only.
REQ-017: IDLE, accept cycle T: fu_op_o/operands/instr/rd driven combinationally from the winner; all other cycles fu_op_o=IDLE_OP, other FU outputs 0.
REQ-018: On accept: last_grant <= winner, winner index latched as owner, state -> BUSY.
REQ-019: BUSY: wait for fu_valid_i (nominally T+1, unbounded wait allowed); capture fu_result_i and owner's rd into response register, resp_err=0, state -> RESP.
REQ-020: RESP: resp_valid_o[owner]=1 with payload held stable until resp_ready_i[owner]=1; req_ready_o all 0.
REQ-021: Accepted XOR_R while seeded=0 is not issued to FU; state IDLE -> RESP directly with result 0, resp_err=1.
REQ-022: seeded flag: set on accept of PRNG with instr[27:25]=3'b101; cleared on accept of PRNG with instr[27:25]=3'b111; unchanged otherwise.
REQ-023: Response handshake of a seed op with WARMUP_CYCLES>0 -> WARMUP with counter=WARMUP_CYCLES; otherwise -> IDLE.
REQ-024: WARMUP: req_ready_o all 0, counter decrements each cycle, -> IDLE in the cycle it reaches 1; exactly WARMUP_CYCLES cycles.
REQ-025: No accept in the cycle of a response handshake; earliest next accept is the following cycle (min 3 cycles per op).
REQ-026: resp_ready_i bits of non-owners and req_valid_i during BUSY/RESP/WARMUP are ignored; requesters hold valid until accepted.
REQ-027: fu_valid_i outside BUSY is ignored.

Reset
REQ-028: rst_i asserted at any time: state=IDLE, last_grant=NR_REQ-1 (requester 0 first), seeded=0, counter=0, response register=0, req_ready_o=0 during reset, resp_valid_o=0, fu_op_o=IDLE_OP; in-flight operation dropped without response.
REQ-029: First accept is possible in the first clock edge after rst_i deasserts.

Verification
REQ-030: Reqs 0 and 1 both valid continuously with SHA256 ops -> grants alternate 0,1,0,1; each response 2 cycles after its accept with the FU result.
REQ-031: XOR_R from req 1 after reset with no seed -> no FU issue (fu_op_o stays IDLE_OP), resp_valid_o=2'b10, resp_err_o=1, result 0.
REQ-032: PRNG seed (instr[27:25]=101), WARMUP_CYCLES=4 -> after response handshake req_ready_o=0 exactly 4 cycles; then XOR_R issued, resp_err_o=0.
REQ-033: resp_ready_i held low 10 cycles -> resp_valid_o and payload stable, no new accept; ready high -> accept next cycle.
REQ-034: rst_i pulsed in BUSY -> no response, seeded=0, next grant to requester 0.
REQ-035: fu_valid_i delayed 5 cycles -> stays BUSY, response carries delayed fu_result_i.
